mc_cu: RTL and testbench
========================

Name: mc_cu

Overview:
- Multi-cycle control unit for the shared-memory MIPS datapath.
- A single memory port serves both instruction fetch and data access, so each instruction takes 3-5 states plus memory wait cycles.
- Sequences the datapath through IF/ID/EXE/MEM/WB and drives every datapath enable, mux select and ALU code.
- Sits between the IR/zero flag and the datapath registers, and owns the memory request handshake.

Parameters:
- STATE_W, 3, width of the state register; states are encoded 0-4.
- WAIT_MAX, 15, maximum cycles a memory access may wait for ack before the controller abandons it; 0 disables the timeout.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  6  IR[31:26].
- func  in  6  IR[5:0].
- z  in  1  ALU zero flag, valid in EXE.
- mem_ack  in  1  memory completes the access in this cycle.
- mem_req  out  1  memory access request.
- iord  out  1  memory address select: 0 = pc, 1 = ALU output register.
- wmem  out  1  memory write strobe, qualified by mem_req.
- wir  out  1  IR write enable.
- wpc  out  1  pc write enable.
- wtgt  out  1  branch-target register write enable.
- wreg  out  1  register file write enable.
- regrt  out  1  destination register select: 1 = rt, 0 = rd.
- m2reg  out  1  writeback data select: 1 = memory data register.
- jal  out  1  force destination r31 and write data = pc.
- shift  out  1  ALU A input = sa.
- alusrca  out  1  ALU A input: 0 = pc, 1 = register A.
- alusrcb  out  2  ALU B input: 00 = register B, 01 = constant 4, 10 = immediate, 11 = immediate<<2.
- sext  out  1  immediate is sign-extended.
- aluc  out  4  ALU operation code.
- pcsource  out  2  next-pc select: 00 = ALU result, 01 = target register, 10 = register A (jr), 11 = jump address.
- state  out  STATE_W  current state, for debug.
- mem_timeout  out  1  one-cycle pulse when a memory access is abandoned.

Behaviour:
- Encodings:
  - States: IF=0, ID=1, EXE=2, MEM=3, WB=4.
  - aluc: add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110, sll 0011, srl 0111, sra 1111.
- Reset: state=IF and the wait counter is cleared. While reset is high, mem_req, wmem, wir, wpc, wtgt and wreg are 0; all other outputs are 0.
- Output timing: all outputs are combinational from state and op/func. The only registered elements are state and the wait counter.
- IF:
  - mem_req=1, iord=0, alusrca=0, alusrcb=01, aluc=add, pcsource=00.
  - Stay in IF until mem_ack. In the ack cycle, wir=1 and wpc=1, then go to ID.
- ID:
  - alusrca=0, alusrcb=11, sext=1, aluc=add, wtgt=1.
  - j: wpc=1, pcsource=11, then IF.
  - jr: wpc=1, pcsource=10, then IF.
  - jal: wpc=1, pcsource=11, wreg=1, jal=1, then IF. The register file captures the old pc on the same edge.
  - Illegal or unsupported opcode/func: no writes, then IF (treated as a NOP).
  - All other instructions go to EXE.
- EXE:
  - Shared settings: alusrca=1, shift=sll|srl|sra.
  - R-type: alusrcb=00, aluc by func, then WB.
  - addi/andi/ori/xori/lui: alusrcb=10. sext=1 only for addi. aluc by op. Then WB.
  - lw/sw: alusrcb=10, sext=1, aluc=add, then MEM.
  - beq/bne: alusrcb=00, aluc=sub. wpc = (beq&z)|(bne&~z) with pcsource=01. Then IF.
- MEM:
  - mem_req=1, iord=1, wmem=sw. Hold until mem_ack.
  - In the ack cycle: sw goes to IF; lw goes to WB.
- WB:
  - wreg=1. regrt=1 for I-type, 0 for R-type. m2reg=lw.
  - Then IF.
- Cycle counts with zero-wait memory: j/jr/jal 2; beq/bne 3; R-type/ALU-immediate 4; sw 4; lw 5.
- Wait counter:
  - Counts cycles in which mem_req=1 and mem_ack=0; cleared on any state change.
  - If WAIT_MAX!=0 and the counter reaches WAIT_MAX, pulse mem_timeout for one cycle and go to IF with no write enables asserted.
  - The counter saturates and never wraps.
- mem_ack outside IF/MEM is ignored.
- Reset asserted mid-access: mem_req drops asynchronously and the access is abandoned. There is no partial write, because wmem is gated by reset.

Optional Feature:
- Macro: MC_CU_PERF_CNT_EN.
- Defined: adds outputs cyc_cnt[31:0] and instr_cnt[31:0].
  - cyc_cnt increments every cycle out of reset.
  - instr_cnt increments on every transition into IF from ID, EXE, MEM or WB, including timeouts and NOPs.
  - Both clear on reset and wrap modulo 2^32.
- Undefined: no counters and no extra ports.

Decomposition:
- Package mc_cu_pkg holds:
  - opcode and func constants;
  - the state enum;
  - aluc codes;
  - the pcsource and alusrcb encodings.
- Sub-module mc_decode is purely combinational. It maps op/func to one-hot instruction flags (i_add ... i_jal) plus an illegal flag. mc_cu instantiates it once.

Test Plan:
- Reset asserted in IF with mem_ack low -> mem_req=0 immediately; after release, state=IF and mem_req=1.
- add (op=0, func=100000) with zero-wait ack -> states IF,ID,EXE,WB. wreg=1 only in WB, regrt=0, aluc=0000 in EXE.
- lw with mem_ack delayed 2 cycles in both IF and MEM -> 9 cycles total; m2reg=1 and regrt=1 in WB; wir pulses exactly once.
- beq with z=1, then again with z=0 -> wpc=1 with pcsource=01 in EXE for z=1; wpc=0 for z=0. Both return to IF after 3 cycles.
- jal, then op=111111 (illegal) -> jal: ID asserts wpc, wreg, jal and pcsource=11. Illegal opcode: ID asserts no write enables and returns to IF.
- WAIT_MAX=3 with mem_ack held low in MEM for sw -> mem_timeout pulses on the 3rd wait cycle, wmem is never acked, and state=IF.

Source files
------------

// File: rtl/mc_cu_pkg.sv
// Shared constants and types for the multi-cycle MIPS control unit:
// opcode/func codes, state encodings, ALU codes and datapath mux encodings.
package mc_cu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ST_IF  = 3'd0;
    localparam logic [2:0] ST_ID  = 3'd1;
    localparam logic [2:0] ST_EXE = 3'd2;
    localparam logic [2:0] ST_MEM = 3'd3;
    localparam logic [2:0] ST_WB  = 3'd4;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    typedef enum logic [1:0] {
        PCSRC_ALU  = 2'b00,
        PCSRC_TGT  = 2'b01,
        PCSRC_REGA = 2'b10,
        PCSRC_JUMP = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        SRCB_REGB   = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } srcb_e;

    typedef struct packed {
        logic is_add;
        logic is_sub;
        logic is_and;
        logic is_or;
        logic is_xor;
        logic is_sll;
        logic is_srl;
        logic is_sra;
        logic is_jr;
        logic is_addi;
        logic is_andi;
        logic is_ori;
        logic is_xori;
        logic is_lui;
        logic is_lw;
        logic is_sw;
        logic is_beq;
        logic is_bne;
        logic is_j;
        logic is_jal;
    } instr_t;

    // ALU code for register and immediate arithmetic; anything else adds.
    function automatic logic [3:0] alu_code(input instr_t f);
        logic [3:0] code;
        code = ALUC_ADD;
        if (f.is_sub)                 code = ALUC_SUB;
        else if (f.is_and | f.is_andi) code = ALUC_AND;
        else if (f.is_or  | f.is_ori)  code = ALUC_OR;
        else if (f.is_xor | f.is_xori) code = ALUC_XOR;
        else if (f.is_lui)             code = ALUC_LUI;
        else if (f.is_sll)             code = ALUC_SLL;
        else if (f.is_srl)             code = ALUC_SRL;
        else if (f.is_sra)             code = ALUC_SRA;
        return code;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: op/func to one-hot instruction flags,
// with an illegal flag when no supported instruction matches.
module mc_decode
    import mc_cu_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_func,
    output instr_t     o_instr,
    output logic       o_illegal
);

    always_comb begin
        o_instr = '0;
        case (i_op)
            OP_RTYPE: begin
                case (i_func)
                    FN_ADD:  o_instr.is_add = 1'b1;
                    FN_SUB:  o_instr.is_sub = 1'b1;
                    FN_AND:  o_instr.is_and = 1'b1;
                    FN_OR:   o_instr.is_or  = 1'b1;
                    FN_XOR:  o_instr.is_xor = 1'b1;
                    FN_SLL:  o_instr.is_sll = 1'b1;
                    FN_SRL:  o_instr.is_srl = 1'b1;
                    FN_SRA:  o_instr.is_sra = 1'b1;
                    FN_JR:   o_instr.is_jr  = 1'b1;
                    default: ;
                endcase
            end
            OP_ADDI: o_instr.is_addi = 1'b1;
            OP_ANDI: o_instr.is_andi = 1'b1;
            OP_ORI:  o_instr.is_ori  = 1'b1;
            OP_XORI: o_instr.is_xori = 1'b1;
            OP_LUI:  o_instr.is_lui  = 1'b1;
            OP_LW:   o_instr.is_lw   = 1'b1;
            OP_SW:   o_instr.is_sw   = 1'b1;
            OP_BEQ:  o_instr.is_beq  = 1'b1;
            OP_BNE:  o_instr.is_bne  = 1'b1;
            OP_J:    o_instr.is_j    = 1'b1;
            OP_JAL:  o_instr.is_jal  = 1'b1;
            default: ;
        endcase
    end

    assign o_illegal = (o_instr == '0);

endmodule

// File: rtl/mc_cu.sv
// Multi-cycle control unit for the shared-memory MIPS datapath.
// Define MC_CU_PERF_CNT_EN to add the cycle and retired-instruction counters.
module mc_cu
    import mc_cu_pkg::*;
#(
    parameter int unsigned STATE_W  = 3,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [5:0]         i_op,
    input  logic [5:0]         i_func,
    input  logic               i_z,
    input  logic               i_mem_ack,
    output logic               o_mem_req,
    output logic               o_iord,
    output logic               o_wmem,
    output logic               o_wir,
    output logic               o_wpc,
    output logic               o_wtgt,
    output logic               o_wreg,
    output logic               o_regrt,
    output logic               o_m2reg,
    output logic               o_jal,
    output logic               o_shift,
    output logic               o_alusrca,
    output logic [1:0]         o_alusrcb,
    output logic               o_sext,
    output logic [3:0]         o_aluc,
    output logic [1:0]         o_pcsource,
    output logic [STATE_W-1:0] o_state,
`ifdef MC_CU_PERF_CNT_EN
    output logic [31:0]        o_cyc_cnt,
    output logic [31:0]        o_instr_cnt,
`endif
    output logic               o_mem_timeout
);

    localparam logic [STATE_W-1:0] S_IF  = STATE_W'(ST_IF);
    localparam logic [STATE_W-1:0] S_ID  = STATE_W'(ST_ID);
    localparam logic [STATE_W-1:0] S_EXE = STATE_W'(ST_EXE);
    localparam logic [STATE_W-1:0] S_MEM = STATE_W'(ST_MEM);
    localparam logic [STATE_W-1:0] S_WB  = STATE_W'(ST_WB);

    localparam int unsigned CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [CNT_W-1:0]   r_wait;
    instr_t             w_instr;
    logic               w_illegal;
    logic               w_rtype;
    logic               w_alu_imm;

    mc_decode u_decode (
        .i_op      (i_op),
        .i_func    (i_func),
        .o_instr   (w_instr),
        .o_illegal (w_illegal)
    );

    assign w_rtype   = w_instr.is_add | w_instr.is_sub | w_instr.is_and | w_instr.is_or |
                       w_instr.is_xor | w_instr.is_sll | w_instr.is_srl | w_instr.is_sra;
    assign w_alu_imm = w_instr.is_addi | w_instr.is_andi | w_instr.is_ori |
                       w_instr.is_xori | w_instr.is_lui;

    always_comb begin
        w_state_nxt   = r_state;
        o_mem_req     = 1'b0;
        o_iord        = 1'b0;
        o_wmem        = 1'b0;
        o_wir         = 1'b0;
        o_wpc         = 1'b0;
        o_wtgt        = 1'b0;
        o_wreg        = 1'b0;
        o_regrt       = 1'b0;
        o_m2reg       = 1'b0;
        o_jal         = 1'b0;
        o_shift       = 1'b0;
        o_alusrca     = 1'b0;
        o_alusrcb     = SRCB_REGB;
        o_sext        = 1'b0;
        o_aluc        = ALUC_ADD;
        o_pcsource    = PCSRC_ALU;
        o_mem_timeout = 1'b0;

        case (r_state)
            S_IF: begin
                o_mem_req = 1'b1;
                o_alusrcb = SRCB_FOUR;
                if (i_mem_ack) begin
                    o_wir       = 1'b1;
                    o_wpc       = 1'b1;
                    w_state_nxt = S_ID;
                end
            end
            S_ID: begin
                o_alusrcb   = SRCB_IMM_SH;
                o_sext      = 1'b1;
                w_state_nxt = S_EXE;
                if (w_illegal) begin
                    w_state_nxt = S_IF;
                end else begin
                    o_wtgt = 1'b1;
                    if (w_instr.is_j | w_instr.is_jal) begin
                        o_wpc       = 1'b1;
                        o_pcsource  = PCSRC_JUMP;
                        o_wreg      = w_instr.is_jal;
                        o_jal       = w_instr.is_jal;
                        w_state_nxt = S_IF;
                    end else if (w_instr.is_jr) begin
                        o_wpc       = 1'b1;
                        o_pcsource  = PCSRC_REGA;
                        w_state_nxt = S_IF;
                    end
                end
            end
            S_EXE: begin
                o_alusrca = 1'b1;
                o_shift   = w_instr.is_sll | w_instr.is_srl | w_instr.is_sra;
                if (w_rtype) begin
                    o_aluc      = alu_code(w_instr);
                    w_state_nxt = S_WB;
                end else if (w_alu_imm) begin
                    o_alusrcb   = SRCB_IMM;
                    o_sext      = w_instr.is_addi;
                    o_aluc      = alu_code(w_instr);
                    w_state_nxt = S_WB;
                end else if (w_instr.is_lw | w_instr.is_sw) begin
                    o_alusrcb   = SRCB_IMM;
                    o_sext      = 1'b1;
                    w_state_nxt = S_MEM;
                end else begin
                    o_aluc      = ALUC_SUB;
                    o_wpc       = (w_instr.is_beq & i_z) | (w_instr.is_bne & ~i_z);
                    o_pcsource  = PCSRC_TGT;
                    w_state_nxt = S_IF;
                end
            end
            S_MEM: begin
                o_mem_req = 1'b1;
                o_iord    = 1'b1;
                o_wmem    = w_instr.is_sw;
                if (i_mem_ack) begin
                    w_state_nxt = w_instr.is_sw ? S_IF : S_WB;
                end
            end
            S_WB: begin
                o_wreg      = 1'b1;
                o_regrt     = ~w_rtype;
                o_m2reg     = w_instr.is_lw;
                w_state_nxt = S_IF;
            end
            default: w_state_nxt = S_IF;
        endcase

        // Abandon the access on the cycle that would make WAIT_MAX unacked cycles.
        if (WAIT_MAX != 0 && o_mem_req && !i_mem_ack && r_wait == CNT_W'(WAIT_MAX - 1)) begin
            o_mem_timeout = 1'b1;
            w_state_nxt   = S_IF;
        end

        // Reset must kill the request and every strobe without waiting for a clock.
        if (i_reset) begin
            o_mem_req     = 1'b0;
            o_iord        = 1'b0;
            o_wmem        = 1'b0;
            o_wir         = 1'b0;
            o_wpc         = 1'b0;
            o_wtgt        = 1'b0;
            o_wreg        = 1'b0;
            o_regrt       = 1'b0;
            o_m2reg       = 1'b0;
            o_jal         = 1'b0;
            o_shift       = 1'b0;
            o_alusrca     = 1'b0;
            o_alusrcb     = SRCB_REGB;
            o_sext        = 1'b0;
            o_aluc        = ALUC_ADD;
            o_pcsource    = PCSRC_ALU;
            o_mem_timeout = 1'b0;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A timeout from IF stays in IF, so it must clear the counter explicitly.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wait <= '0;
        end else if (w_state_nxt != r_state || o_mem_timeout) begin
            r_wait <= '0;
        end else if (o_mem_req && !i_mem_ack && r_wait != '1) begin
            r_wait <= r_wait + CNT_W'(1);
        end
    end

    assign o_state = r_state;

`ifdef MC_CU_PERF_CNT_EN
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_instr_cnt;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cyc_cnt   <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
            if (w_state_nxt == S_IF && r_state != S_IF) begin
                r_instr_cnt <= r_instr_cnt + 32'd1;
            end
        end
    end

    assign o_cyc_cnt   = r_cyc_cnt;
    assign o_instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_mc_cu.sv
// Directed bench for mc_cu: state traces, per-state strobes, timeouts and reset.
module tb_mc_cu;

    logic       clock;
    logic       reset;
    logic [5:0] op;
    logic [5:0] func;
    logic       z;
    logic       mem_ack;
    logic       mem_req, iord, wmem, wir, wpc, wtgt, wreg, regrt, m2reg, jal, shift;
    logic       alusrca, sext, mem_timeout;
    logic [1:0] alusrcb, pcsource;
    logic [3:0] aluc;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-run observations
    int          cycles, n_wir, n_wreg, n_to;
    logic [63:0] trace;
    logic [3:0]  id_w;
    logic [1:0]  id_pcsrc, exe_pcsrc, exe_srcb;
    logic [3:0]  exe_aluc;
    logic        exe_wpc, exe_shift, exe_sext, mem_wmem, wb_regrt, wb_m2reg;

    mc_cu #(
        .STATE_W  (3),
        .WAIT_MAX (3)
    ) u_dut (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_op          (op),
        .i_func        (func),
        .i_z           (z),
        .i_mem_ack     (mem_ack),
        .o_mem_req     (mem_req),
        .o_iord        (iord),
        .o_wmem        (wmem),
        .o_wir         (wir),
        .o_wpc         (wpc),
        .o_wtgt        (wtgt),
        .o_wreg        (wreg),
        .o_regrt       (regrt),
        .o_m2reg       (m2reg),
        .o_jal         (jal),
        .o_shift       (shift),
        .o_alusrca     (alusrca),
        .o_alusrcb     (alusrcb),
        .o_sext        (sext),
        .o_aluc        (aluc),
        .o_pcsource    (pcsource),
        .o_state       (state),
        .o_mem_timeout (mem_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one instruction from IF back to IF, acking after the given wait cycles.
    task automatic run_instr(input logic [5:0] op_v, input logic [5:0] func_v, input logic z_v,
                             input int if_wait, input int mem_wait);
        int         w;
        logic       left_if;
        logic       done;
        logic [2:0] s_now;
        w = 0; left_if = 1'b0; done = 1'b0;
        cycles = 0; n_wir = 0; n_wreg = 0; n_to = 0; trace = '0;
        id_w = '0; id_pcsrc = '0; exe_pcsrc = '0; exe_srcb = '0; exe_aluc = '0;
        exe_wpc = 1'b0; exe_shift = 1'b0; exe_sext = 1'b0; mem_wmem = 1'b0;
        wb_regrt = 1'b0; wb_m2reg = 1'b0;
        op = op_v; func = func_v; z = z_v;
        for (int c = 0; c < 30 && !done; c++) begin
            s_now = state;
            if (s_now == 3'd0)      mem_ack = (w >= if_wait);
            else if (s_now == 3'd3) mem_ack = (w >= mem_wait);
            else                    mem_ack = 1'b1;
            #1;
            trace = (trace << 4) | 64'(state);
            cycles++;
            if (wir) n_wir++;
            if (wreg) n_wreg++;
            if (mem_timeout) n_to++;
            case (s_now)
                3'd1: begin id_w = {wpc, wreg, wtgt, jal}; id_pcsrc = pcsource; end
                3'd2: begin
                    exe_aluc = aluc; exe_wpc = wpc; exe_pcsrc = pcsource;
                    exe_shift = shift; exe_sext = sext; exe_srcb = alusrcb;
                end
                3'd3: mem_wmem = wmem;
                3'd4: begin wb_regrt = regrt; wb_m2reg = m2reg; end
                default: ;
            endcase
            @(negedge clock);
            if (state != s_now) w = 0; else w++;
            if (state != 3'd0) left_if = 1'b1;
            if (left_if && state == 3'd0) done = 1'b1;
        end
        if (!done) cycles = -1;
        mem_ack = 1'b0;
    endtask

    initial begin
        int pulses;
        reset = 1'b1; op = '0; func = '0; z = 1'b0; mem_ack = 1'b0;
        #1;
        check_eq("rst_mem_req", 64'(mem_req), 64'd0);
        check_eq("rst_state", 64'(state), 64'd0);
        check_eq("rst_strobes", 64'({wir, wpc, wreg, wtgt, wmem}), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("if_state", 64'(state), 64'd0);
        check_eq("if_mem_req", 64'(mem_req), 64'd1);
        check_eq("if_srcs", 64'({iord, alusrca, alusrcb, aluc}), 64'h010);

        // add
        run_instr(6'b000000, 6'b100000, 1'b0, 0, 0);
        check_eq("add_trace", trace, 64'h0124);
        check_eq("add_cycles", 64'(cycles), 64'd4);
        check_eq("add_wreg_cnt", 64'(n_wreg), 64'd1);
        check_eq("add_regrt", 64'(wb_regrt), 64'd0);
        check_eq("add_aluc", 64'(exe_aluc), 64'h0);
        check_eq("add_srcb", 64'(exe_srcb), 64'd0);

        // lw with two wait cycles in IF and MEM
        run_instr(6'b100011, 6'b000000, 1'b0, 2, 2);
        check_eq("lw_trace", trace, 64'h000123334);
        check_eq("lw_cycles", 64'(cycles), 64'd9);
        check_eq("lw_wir_cnt", 64'(n_wir), 64'd1);
        check_eq("lw_wb", 64'({wb_m2reg, wb_regrt}), 64'b11);
        check_eq("lw_wmem", 64'(mem_wmem), 64'd0);

        // beq taken / not taken, bne taken
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
        check_eq("beq1_trace", trace, 64'h012);
        check_eq("beq1_wpc_src", 64'({exe_wpc, exe_pcsrc}), 64'b101);
        check_eq("beq1_aluc", 64'(exe_aluc), 64'h4);
        run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);
        check_eq("beq0_wpc", 64'(exe_wpc), 64'd0);
        check_eq("beq0_cycles", 64'(cycles), 64'd3);
        run_instr(6'b000101, 6'b000000, 1'b0, 0, 0);
        check_eq("bne0_wpc", 64'(exe_wpc), 64'd1);

        // jumps and an illegal opcode
        run_instr(6'b000011, 6'b000000, 1'b0, 0, 0);
        check_eq("jal_trace", trace, 64'h01);
        check_eq("jal_id_w", 64'(id_w), 64'b1111);
        check_eq("jal_pcsrc", 64'(id_pcsrc), 64'd3);
        run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);
        check_eq("j_id_w", 64'(id_w), 64'b1010);
        run_instr(6'b000000, 6'b001000, 1'b0, 0, 0);
        check_eq("jr_id_w_src", 64'({id_w, id_pcsrc}), 64'b101010);
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
        check_eq("ill_trace", trace, 64'h01);
        check_eq("ill_id_w", 64'(id_w), 64'd0);

        // shifts and immediates
        run_instr(6'b000000, 6'b000011, 1'b0, 0, 0);
        check_eq("sra_aluc_shift", 64'({exe_shift, exe_aluc}), 64'h1F);
        run_instr(6'b001101, 6'b000000, 1'b0, 0, 0);
        check_eq("ori_exe", 64'({exe_sext, exe_srcb, exe_aluc}), 64'b0_10_0101);
        check_eq("ori_regrt", 64'(wb_regrt), 64'd1);
        run_instr(6'b001000, 6'b000000, 1'b0, 0, 0);
        check_eq("addi_exe", 64'({exe_sext, exe_aluc}), 64'b1_0000);

        // sw normal, then abandoned in MEM
        run_instr(6'b101011, 6'b000000, 1'b0, 0, 0);
        check_eq("sw_trace", trace, 64'h0123);
        check_eq("sw_wmem", 64'(mem_wmem), 64'd1);
        run_instr(6'b101011, 6'b000000, 1'b0, 0, 100);
        check_eq("swto_trace", trace, 64'h012333);
        check_eq("swto_pulses", 64'(n_to), 64'd1);
        check_eq("swto_wreg", 64'(n_wreg), 64'd0);

        // fetch that never acks: a pulse every third cycle
        mem_ack = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (mem_timeout) pulses++;
            @(negedge clock);
        end
        check_eq("ifto_pulses", 64'(pulses), 64'd2);
        check_eq("ifto_state", 64'(state), 64'd0);

        // reset in the middle of a store
        op = 6'b101011; func = '0; mem_ack = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #1;
        check_eq("mid_pre", 64'({state, mem_req, wmem}), 64'b011_1_1);
        #1;
        reset = 1'b1;
        #1;
        check_eq("mid_rst", 64'({state, mem_req, wmem}), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("mid_post", 64'({state, mem_req}), 64'b000_1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
